// File: rtl/simon_pkg.sv
// Shared types for the Simon Says input controller.
// Colours, PS/2 make codes and controller states.
package simon_pkg;

  typedef enum logic [1:0] {
    C_GREEN  = 2'd0,
    C_RED    = 2'd1,
    C_YELLOW = 2'd2,
    C_BLUE   = 2'd3
  } colour_t;

  localparam logic [7:0] SC_GREEN  = 8'h1C;
  localparam logic [7:0] SC_RED    = 8'h1B;
  localparam logic [7:0] SC_YELLOW = 8'h23;
  localparam logic [7:0] SC_BLUE   = 8'h2B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_REPORT
  } in_state_t;

  typedef struct packed {
    logic    vld;
    colour_t colour;
  } key_map_t;

  function automatic key_map_t map_code(
    input logic [7:0] code
  );
    key_map_t m;
    m.vld    = 1'b1;
    m.colour = C_GREEN;
    unique case (1'b1)
      (code == SC_GREEN):  m.colour = C_GREEN;
      (code == SC_RED):    m.colour = C_RED;
      (code == SC_YELLOW): m.colour = C_YELLOW;
      (code == SC_BLUE):   m.colour = C_BLUE;
      default:             m.vld    = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/simon_key_fifo.sv
// Small synchronous FIFO for buffered colour keys.
// Flush wins over push; a push into a full FIFO succeeds only with a pop.
module simon_key_fifo
  import simon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/simon_input_ctrl.sv
// Simon Says input controller: PS/2 key mapping, type-ahead
// buffering and one hit/miss/timeout check per arm request.
module simon_input_ctrl
  import simon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 150_000_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_pulse,
  input  logic [7:0]                    key_code,
  input  logic                          flush,
  input  logic                          arm,
  input  logic                          abort,
  input  logic [1:0]                    expected,
  output logic                          busy,
  output logic                          result_valid,
  output logic                          result_hit,
  output logic                          result_timeout,
  output logic [1:0]                    result_color,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf,
  input  logic                          clr_ovf
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  key_map_t  km;
  logic      key_vld;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic [1:0] fifo_dout;
  logic      ovf_set;

  in_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic      expired_q, expired_d;
  colour_t   exp_q, exp_d;
  logic      res_load;
  logic      res_hit_d;
  logic      res_tmo_d;
  logic [1:0] res_col_d;

  assign km      = map_code(key_code);
  assign key_vld = key_pulse && km.vld;
  assign ovf_set = key_vld && fifo_full && !fifo_pop && !flush;

  simon_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_vld),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (km.colour),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Expiry is registered, so a key landing on the limit cycle cannot
  // rescue the window; it stays buffered for the next check.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    expired_d = expired_q;
    exp_d     = exp_q;
    fifo_pop  = 1'b0;
    res_load  = 1'b0;
    res_hit_d = 1'b0;
    res_tmo_d = 1'b0;
    res_col_d = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          exp_d     = colour_t'(expected);
          timer_d   = '0;
          expired_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (expired_q) begin
          state_d   = ST_REPORT;
          res_load  = 1'b1;
          res_tmo_d = 1'b1;
        end else if (!fifo_empty) begin
          state_d = ST_CHECK;
        end else if (timer_q == T_LAST) begin
          expired_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          fifo_pop  = 1'b1;
          res_load  = 1'b1;
          res_hit_d = (fifo_dout == exp_q);
          res_col_d = fifo_dout;
          state_d   = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      expired_q <= 1'b0;
      exp_q     <= C_GREEN;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      expired_q <= expired_d;
      exp_q     <= exp_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_hit     <= 1'b0;
      result_timeout <= 1'b0;
      result_color   <= 2'd0;
      ovf            <= 1'b0;
    end else begin
      busy         <= (state_d != ST_IDLE);
      result_valid <= res_load;
      if (res_load) begin
        result_hit     <= res_hit_d;
        result_timeout <= res_tmo_d;
        result_color   <= res_col_d;
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simon_input_ctrl.sv
// Bench for simon_input_ctrl: directed steps plus random
// key/arm rounds against a queue-based reference model.
module tb_simon_input_ctrl;

  localparam int TC = 10;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_pulse;
  logic [7:0] key_code;
  logic       flush;
  logic       arm;
  logic       abort;
  logic [1:0] expected;
  logic       busy;
  logic       result_valid;
  logic       result_hit;
  logic       result_timeout;
  logic [1:0] result_color;
  logic [2:0] fifo_count;
  logic       ovf;
  logic       clr_ovf;

  int checks = 0;
  int failures = 0;
  int q[$];
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  simon_input_ctrl #(
    .TIMEOUT_CYCLES (TC),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_pulse      (key_pulse),
    .key_code       (key_code),
    .flush          (flush),
    .arm            (arm),
    .abort          (abort),
    .expected       (expected),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_hit     (result_hit),
    .result_timeout (result_timeout),
    .result_color   (result_color),
    .fifo_count     (fifo_count),
    .ovf            (ovf),
    .clr_ovf        (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int map(input logic [7:0] c);
    case (c)
      8'h1C:   return 0;
      8'h1B:   return 1;
      8'h23:   return 2;
      8'h2B:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic m_push(input logic [7:0] c);
    int m;
    m = map(c);
    if (m >= 0) begin
      if (q.size() == FD) m_ovf = 1'b1;
      else q.push_back(m);
    end
  endtask

  task automatic send(input logic [7:0] c);
    key_code  = c;
    key_pulse = 1'b1;
    tick();
    key_pulse = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic wait_rv(input int start, output int lat);
    lat = start;
    while (result_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic arm_check(input logic [1:0] e, input string tag);
    int lat, xlat;
    logic xh, xt;
    logic [1:0] xc;
    if (q.size() > 0) begin
      xlat = 3;
      xc   = 2'(q[0]);
      xh   = (q[0] == int'(e));
      xt   = 1'b0;
      void'(q.pop_front());
    end else begin
      xlat = TC + 2;
      xc   = 2'd0;
      xh   = 1'b0;
      xt   = 1'b1;
    end
    expected = e;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_rv(1, lat);
    chk({tag, "_lat"}, lat, xlat);
    chk({tag, "_hit"}, result_hit, xh);
    chk({tag, "_tmo"}, result_timeout, xt);
    chk({tag, "_col"}, result_color, xc);
    chk({tag, "_busy"}, busy, 1);
    tick();
    chk({tag, "_rv_drop"}, result_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, result_color, xc);
    chk({tag, "_cnt"}, fifo_count, q.size());
  endtask

  initial begin
    int lat, seen, n;
    logic [7:0] codes [6];
    codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h23;
    codes[3] = 8'h2B; codes[4] = 8'h5A; codes[5] = 8'h00;
    rst = 1'b0; key_pulse = 1'b0; key_code = 8'h00; flush = 1'b0;
    arm = 1'b0; abort = 1'b0; expected = 2'd0; clr_ovf = 1'b0;

    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_hit", result_hit, 0);
    chk("rst_tmo", result_timeout, 0);
    chk("rst_col", result_color, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    tick();

    send(8'h1B); m_push(8'h1B);
    chk("ta_cnt", fifo_count, 1);
    arm_check(2'd1, "typeahead");

    expected = 2'd2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    send(8'h2B);
    wait_rv(1, lat);
    chk("miss_lat", lat, 3);
    chk("miss_hit", result_hit, 0);
    chk("miss_col", result_color, 3);
    chk("miss_tmo", result_timeout, 0);
    tick();

    arm_check(2'd0, "timeout");

    expected = 2'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (9) tick();
    send(8'h23); m_push(8'h23);
    wait_rv(11, lat);
    chk("late_lat", lat, TC + 2);
    chk("late_tmo", result_timeout, 1);
    chk("late_col", result_color, 0);
    tick();
    chk("late_cnt", fifo_count, q.size());
    flush = 1'b1; tick(); flush = 1'b0; q.delete();
    chk("flush_cnt", fifo_count, 0);

    repeat (5) begin send(8'h1C); m_push(8'h1C); end
    chk("ovf_cnt", fifo_count, 4);
    chk("ovf_set", ovf, m_ovf);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; m_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);
    send(8'h5A); m_push(8'h5A);
    chk("ign_cnt", fifo_count, 4);
    chk("ign_ovf", ovf, 0);
    clr_ovf = 1'b1; send(8'h1C); clr_ovf = 1'b0;
    chk("ovf_setwins", ovf, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; m_ovf = 1'b0;
    flush = 1'b1; send(8'h1B); flush = 1'b0; q.delete();
    chk("flushkey_cnt", fifo_count, 0);

    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    seen = 0;
    repeat (TC + 6) begin
      if (result_valid === 1'b1) seen++;
      tick();
    end
    chk("abort_norv", seen, 0);
    flush = 1'b1; send(8'h2B); flush = 1'b0;
    chk("abort_flush_cnt", fifo_count, 0);

    send(8'h1C); send(8'h1B); send(8'h23);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("ar_busy", busy, 1);
    chk("ar_cnt", fifo_count, 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy0", busy, 0);
    chk("ar_rv0", result_valid, 0);
    chk("ar_tmo0", result_timeout, 0);
    chk("ar_cnt0", fifo_count, 0);
    chk("ar_ovf0", ovf, 0);
    #2 rst = 1'b1;
    tick();
    chk("ar_cnt_rel", fifo_count, 0);
    q.delete(); m_ovf = 1'b0;

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        logic [7:0] c;
        c = codes[$urandom_range(0, 5)];
        send(c); m_push(c);
      end
      chk("rnd_cnt", fifo_count, q.size());
      chk("rnd_ovf", ovf, m_ovf);
      if ($urandom_range(0, 3) == 0) begin
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; m_ovf = 1'b0;
      end
      arm_check(2'($urandom_range(0, 3)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
